dff_serial_tx: RTL and testbench

- Parallel-to-serial transmitter. It is the driving end of a single-bit serial link whose capture side is a chain of our D flip-flops, each clocked on the same clk.
- Accepts a WIDTH-bit word through a valid/ready handshake.
- Emits the word one bit per clock on sdata, qualified by sframe.
- Provides a complementary sdata_n output, matching the q/q_not pairing of the capture flops.

---
 rtl/dff_serial_tx.sv | 138 +++++++++++++
 tb/tb_dff_serial_tx.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/dff_serial_tx.sv
// dff_serial_tx: parallel-to-serial transmitter feeding a chain of capture flops.
// A word is taken on a valid/ready handshake and shifted out one bit per clock on
// sdata, framed by sframe, followed by an optional idle gap before the next word.
module dff_serial_tx #(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter int GAP_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             sdata,
  output logic             sdata_n,
  output logic             sframe,
  output logic             tx_done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [3:0] GAP_LAST = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t           r_state, w_nextState;
  logic [CW-1:0]    r_bitCnt, w_nextBitCnt;
  logic [3:0]       r_gapCnt, w_nextGapCnt;
  logic [WIDTH-1:0] r_shift, w_nextShift;
  logic             r_sdata, w_nextSdata;
  logic             r_sframe, w_nextSframe;
  logic             r_txDone, w_nextTxDone;
  logic             r_inReady, w_nextInReady;

  logic             w_handshake;
  logic             w_firstBit;
  logic [WIDTH-1:0] w_loadShift;
  logic             w_outBit;
  logic [WIDTH-1:0] w_shifted;

  assign w_handshake = in_valid && r_inReady;

  // The first payload bit goes straight to the sdata register on the handshake
  // edge, so the shift register is loaded already advanced by one position.
  assign w_firstBit  = MSB_FIRST ? in_data[WIDTH-1] : in_data[0];
  assign w_loadShift = MSB_FIRST ? {in_data[WIDTH-2:0], 1'b0} : {1'b0, in_data[WIDTH-1:1]};
  assign w_outBit    = MSB_FIRST ? r_shift[WIDTH-1] : r_shift[0];
  assign w_shifted   = MSB_FIRST ? {r_shift[WIDTH-2:0], 1'b0} : {1'b0, r_shift[WIDTH-1:1]};

  // Next-state and next-output logic; outputs are computed one cycle ahead so
  // that every output except sdata_n comes straight from a flop.
  always_comb begin
    w_nextState   = r_state;
    w_nextBitCnt  = r_bitCnt;
    w_nextGapCnt  = r_gapCnt;
    w_nextShift   = r_shift;
    w_nextSdata   = 1'b0;
    w_nextSframe  = 1'b0;
    w_nextTxDone  = 1'b0;
    w_nextInReady = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_handshake) begin
          w_nextState  = SHIFT;
          w_nextBitCnt = '0;
          w_nextShift  = w_loadShift;
          w_nextSdata  = w_firstBit;
          w_nextSframe = 1'b1;
        end else begin
          w_nextInReady = 1'b1;
        end
      end
      SHIFT: begin
        if (r_bitCnt == CNT_LAST) begin
          w_nextTxDone = 1'b1;
          if (GAP_CYCLES > 0) begin
            w_nextState  = GAP;
            w_nextGapCnt = 4'd0;
          end else begin
            w_nextState   = IDLE;
            w_nextInReady = 1'b1;
          end
        end else begin
          w_nextBitCnt = r_bitCnt + 1'b1;
          w_nextShift  = w_shifted;
          w_nextSdata  = w_outBit;
          w_nextSframe = 1'b1;
        end
      end
      GAP: begin
        if (r_gapCnt == GAP_LAST) begin
          w_nextState   = IDLE;
          w_nextInReady = 1'b1;
        end else begin
          w_nextGapCnt = r_gapCnt + 4'd1;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // State, counters, shift register and registered outputs; reset wins over a
  // simultaneous handshake and aborts any frame in flight without a tx_done.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_bitCnt  <= '0;
      r_gapCnt  <= 4'd0;
      r_shift   <= '0;
      r_sdata   <= 1'b0;
      r_sframe  <= 1'b0;
      r_txDone  <= 1'b0;
      r_inReady <= 1'b0;
    end else begin
      r_state   <= w_nextState;
      r_bitCnt  <= w_nextBitCnt;
      r_gapCnt  <= w_nextGapCnt;
      r_shift   <= w_nextShift;
      r_sdata   <= w_nextSdata;
      r_sframe  <= w_nextSframe;
      r_txDone  <= w_nextTxDone;
      r_inReady <= w_nextInReady;
    end
  end

  assign in_ready = r_inReady;
  assign sdata    = r_sdata;
  assign sdata_n  = ~r_sdata;
  assign sframe   = r_sframe;
  assign tx_done  = r_txDone;

endmodule

// File: tb/tb_dff_serial_tx.sv
// Directed bench for dff_serial_tx. Three instances share one stimulus stream:
// MSB-first with a one-cycle gap, LSB-first with a one-cycle gap, and MSB-first
// with no gap. Inputs are driven and outputs sampled 1 time unit after each edge.
module tb_dff_serial_tx;

  logic       clk;
  logic       rst;
  logic [7:0] inData;
  logic       inValid;

  logic mReady, mSdata, mSdataN, mSframe, mDone;
  logic lReady, lSdata, lSdataN, lSframe, lDone;
  logic gReady, gSdata, gSdataN, gSframe, gDone;

  int checks;
  int errors;

  dff_serial_tx #(.WIDTH(8), .MSB_FIRST(1'b1), .GAP_CYCLES(1)) dutM (
    .clk(clk), .rst(rst), .in_data(inData), .in_valid(inValid),
    .in_ready(mReady), .sdata(mSdata), .sdata_n(mSdataN), .sframe(mSframe), .tx_done(mDone)
  );

  dff_serial_tx #(.WIDTH(8), .MSB_FIRST(1'b0), .GAP_CYCLES(1)) dutL (
    .clk(clk), .rst(rst), .in_data(inData), .in_valid(inValid),
    .in_ready(lReady), .sdata(lSdata), .sdata_n(lSdataN), .sframe(lSframe), .tx_done(lDone)
  );

  dff_serial_tx #(.WIDTH(8), .MSB_FIRST(1'b1), .GAP_CYCLES(0)) dutG (
    .clk(clk), .rst(rst), .in_data(inData), .in_valid(inValid),
    .in_ready(gReady), .sdata(gSdata), .sdata_n(gSdataN), .sframe(gSframe), .tx_done(gDone)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic r, input logic v, input logic [7:0] d);
    rst     = r;
    inValid = v;
    inData  = d;
  endtask

  task automatic checkOutput(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Idle-level outputs of the MSB-first, one-gap instance.
  task automatic checkQuietM(input string tag, input logic expReady, input logic expDone);
    checkOutput({tag, "_sframe"}, mSframe, 1'b0);
    checkOutput({tag, "_sdata"}, mSdata, 1'b0);
    checkOutput({tag, "_sdata_n"}, mSdataN, 1'b1);
    checkOutput({tag, "_in_ready"}, mReady, expReady);
    checkOutput({tag, "_tx_done"}, mDone, expDone);
  endtask

  // Checks the 8 framed cycles of the MSB-first instance, advancing one clock per bit.
  task automatic checkFrameM(input string tag, input logic [7:0] word);
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("%s_bit%0d", tag, i), mSdata, word[7-i]);
      checkOutput($sformatf("%s_n%0d", tag, i), mSdataN, ~word[7-i]);
      checkOutput($sformatf("%s_frame%0d", tag, i), mSframe, 1'b1);
      checkOutput($sformatf("%s_ready%0d", tag, i), mReady, 1'b0);
      checkOutput($sformatf("%s_done%0d", tag, i), mDone, 1'b0);
      tick();
    end
  endtask

  initial begin
    logic [7:0] expM;
    logic [7:0] expL;
    checks = 0;
    errors = 0;

    // Reset held for three edges, then released.
    applyStimulus(1'b1, 1'b0, 8'h00);
    tick();
    checkQuietM("rst1", 1'b0, 1'b0);
    tick();
    tick();
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkQuietM("rst3", 1'b0, 1'b0);
    checkOutput("rst3_g_ready", gReady, 1'b0);
    tick();
    checkQuietM("rel1", 1'b1, 1'b0);
    checkOutput("rel1_l_ready", lReady, 1'b1);

    // Single word 0x1D: MSB-first 0,0,0,1,1,1,0,1 ; LSB-first 1,0,1,1,1,0,0,0.
    expM = 8'b0001_1101;
    expL = 8'b1011_1000;
    applyStimulus(1'b0, 1'b1, 8'h1D);
    tick();
    applyStimulus(1'b0, 1'b0, 8'hFF);
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("w1D_m_bit%0d", i), mSdata, expM[7-i]);
      checkOutput($sformatf("w1D_m_n%0d", i), mSdataN, ~expM[7-i]);
      checkOutput($sformatf("w1D_m_frame%0d", i), mSframe, 1'b1);
      checkOutput($sformatf("w1D_m_done%0d", i), mDone, 1'b0);
      checkOutput($sformatf("w1D_l_bit%0d", i), lSdata, expL[7-i]);
      checkOutput($sformatf("w1D_l_n%0d", i), lSdataN, ~expL[7-i]);
      checkOutput($sformatf("w1D_l_frame%0d", i), lSframe, 1'b1);
      checkOutput($sformatf("w1D_g_bit%0d", i), gSdata, expM[7-i]);
      checkOutput($sformatf("w1D_g_ready%0d", i), gReady, 1'b0);
      tick();
    end
    checkQuietM("w1D_end", 1'b0, 1'b1);
    checkOutput("w1D_l_done", lDone, 1'b1);
    checkOutput("w1D_g_done", gDone, 1'b1);
    checkOutput("w1D_g_ready_nogap", gReady, 1'b1);
    checkOutput("w1D_g_frame_end", gSframe, 1'b0);
    tick();
    checkQuietM("w1D_idle", 1'b1, 1'b0);
    checkOutput("w1D_g_done_once", gDone, 1'b0);

    // Back-to-back 0xFF then 0x00 with in_valid held high: period 10.
    applyStimulus(1'b0, 1'b1, 8'hFF);
    tick();
    checkFrameM("b2bFF", 8'hFF);
    checkQuietM("b2b_gap", 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 8'h00);
    tick();
    checkQuietM("b2b_ready", 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkFrameM("b2b00", 8'h00);
    checkQuietM("b2b00_end", 1'b0, 1'b1);
    tick();
    checkQuietM("b2b00_idle", 1'b1, 1'b0);

    // Busy-ignore: 0x55 offered while 0xA0 is shifting.
    applyStimulus(1'b0, 1'b1, 8'hA0);
    tick();
    applyStimulus(1'b0, 1'b1, 8'h55);
    checkFrameM("busyA0", 8'hA0);
    checkQuietM("busyA0_end", 1'b0, 1'b1);
    tick();
    checkQuietM("busy_ready", 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkFrameM("busy55", 8'h55);
    checkQuietM("busy55_end", 1'b0, 1'b1);
    tick();

    // Mid-frame reset during the 4th bit of 0xF0.
    applyStimulus(1'b0, 1'b1, 8'hF0);
    tick();
    applyStimulus(1'b0, 1'b0, 8'h00);
    tick();
    tick();
    tick();
    checkOutput("abort_bit4", mSdata, 1'b1);
    checkOutput("abort_frame4", mSframe, 1'b1);
    applyStimulus(1'b1, 1'b0, 8'h00);
    tick();
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkQuietM("abort_rst", 1'b0, 1'b0);
    tick();
    checkQuietM("abort_rel", 1'b1, 1'b0);
    tick();
    checkQuietM("abort_nodone", 1'b1, 1'b0);

    // Reset beats a simultaneous handshake.
    applyStimulus(1'b1, 1'b1, 8'h81);
    tick();
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkQuietM("prio_rst", 1'b0, 1'b0);
    tick();
    checkQuietM("prio_rel", 1'b1, 1'b0);

    // Fresh word after the abort transmits intact: 1,0,0,0,0,0,0,1.
    applyStimulus(1'b0, 1'b1, 8'h81);
    tick();
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkFrameM("w81", 8'h81);
    checkQuietM("w81_end", 1'b0, 1'b1);
    tick();
    checkQuietM("w81_idle", 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
